// File: rtl/gray_seq_ctrl.sv
// gray_seq_ctrl: run-control sequencer owning a binary count and its registered Gray image.
// Revision 1.0 - initial release.
`default_nettype none

module gray_seq_ctrl #(
  parameter int CBITS = 9,
  parameter int WRAPW = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CBITS-1:0] cfg_limit,
  input  logic             cfg_wrap,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  output logic [CBITS-1:0] gray_c,
  output logic             running,
  output logic             wrap,
  output logic             done,
  output logic [WRAPW-1:0] wrap_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CBITS-1:0] cnt_q, cnt_d;
  logic [CBITS-1:0] gray_q, gray_d;
  logic [CBITS-1:0] limit_q, limit_d;
  logic             wmode_q, wmode_d;
  logic [WRAPW-1:0] wcnt_q, wcnt_d;
  logic             wrap_q, wrap_d;
  logic             cfg_ready_w;

  assign cfg_ready_w = (state_q == S_IDLE) || (state_q == S_DONE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    limit_d = limit_q;
    wmode_d = wmode_q;
    wcnt_d  = wcnt_q;
    wrap_d  = 1'b0;

    // Config lands on the same edge as a start, so the launched run compares against it next cycle.
    if (cfg_valid && cfg_ready_w) begin
      limit_d = cfg_limit;
      wmode_d = cfg_wrap;
    end

    if (abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      wcnt_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_d = '0;
          if (start) begin
            state_d = S_RUN;
            wcnt_d  = '0;
          end
        end
        S_RUN: begin
          if (pause) begin
            state_d = S_PAUSE;
          end else if (cnt_q != limit_q) begin
            cnt_d = cnt_q + 1'b1;
          end else if (wmode_q) begin
            cnt_d  = '0;
            wrap_d = 1'b1;
            if (wcnt_q != {WRAPW{1'b1}}) wcnt_d = wcnt_q + 1'b1;
          end else begin
            state_d = S_DONE;
          end
        end
        S_PAUSE: begin
          if (start) state_d = S_RUN;
        end
        S_DONE: begin
          if (start) begin
            state_d = S_RUN;
            cnt_d   = '0;
            wcnt_d  = '0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    gray_d = cnt_d ^ (cnt_d >> 1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      gray_q  <= '0;
      limit_q <= '1;
      wmode_q <= 1'b1;
      wcnt_q  <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gray_q  <= gray_d;
      limit_q <= limit_d;
      wmode_q <= wmode_d;
      wcnt_q  <= wcnt_d;
      wrap_q  <= wrap_d;
    end
  end

  assign cfg_ready = cfg_ready_w;
  assign gray_c    = gray_q;
  assign running   = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign wrap      = wrap_q;
  assign wrap_cnt  = wcnt_q;

endmodule

`default_nettype wire

// File: tb/tb_gray_seq_ctrl.sv
// tb_gray_seq_ctrl: scoreboard bench for gray_seq_ctrl with directed sequence checks.
`default_nettype none

module tb_gray_seq_ctrl;

  logic       clk;
  logic       rst;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [8:0] cfg_limit;
  logic       cfg_wrap;
  logic       start;
  logic       pause;
  logic       abort;
  logic [8:0] gray_c;
  logic       running;
  logic       wrap;
  logic       done;
  logic [3:0] wrap_cnt;

  gray_seq_ctrl #(.CBITS(9), .WRAPW(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_limit (cfg_limit),
    .cfg_wrap  (cfg_wrap),
    .start     (start),
    .pause     (pause),
    .abort     (abort),
    .gray_c    (gray_c),
    .running   (running),
    .wrap      (wrap),
    .done      (done),
    .wrap_cnt  (wrap_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] gray;
    logic       run;
    logic       wrp;
    logic       dn;
    logic       rdy;
    logic [3:0] wc;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  // Reference model: 0=IDLE 1=RUN 2=PAUSE 3=DONE
  int         m_st;
  logic [8:0] m_cnt;
  logic [8:0] m_lim;
  logic       m_wm;
  logic [3:0] m_wc;
  logic       m_wrap;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic v, input logic [8:0] lim, input logic wm,
                     input logic st, input logic pa, input logic ab, input logic r);
    exp_t       e;
    exp_t       o;
    logic [8:0] nlim;
    logic       nwm;
    cfg_valid = v; cfg_limit = lim; cfg_wrap = wm;
    start = st; pause = pa; abort = ab; rst = r;
    if (r) begin
      m_st = 0; m_cnt = 0; m_lim = 9'h1FF; m_wm = 1'b1; m_wc = 0; m_wrap = 1'b0;
    end else begin
      nlim = m_lim; nwm = m_wm;
      if (v && (m_st == 0 || m_st == 3)) begin
        nlim = lim; nwm = wm;
      end
      m_wrap = 1'b0;
      if (ab) begin
        m_st = 0; m_cnt = 0; m_wc = 0;
      end else begin
        case (m_st)
          0: if (st) begin m_st = 1; m_wc = 0; end
          1: begin
            if (pa) m_st = 2;
            else if (m_cnt != m_lim) m_cnt = m_cnt + 9'd1;
            else if (m_wm) begin
              m_cnt = 0; m_wrap = 1'b1;
              if (m_wc != 4'hF) m_wc = m_wc + 4'd1;
            end else m_st = 3;
          end
          2: if (st) m_st = 1;
          default: if (st) begin m_st = 1; m_cnt = 0; m_wc = 0; end
        endcase
      end
      m_lim = nlim; m_wm = nwm;
    end
    e.gray = m_cnt ^ (m_cnt >> 1);
    e.run  = (m_st == 1);
    e.wrp  = m_wrap;
    e.dn   = (m_st == 3);
    e.rdy  = (m_st == 0 || m_st == 3);
    e.wc   = m_wc;
    q.push_back(e);
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      o = q.pop_front();
      chk("sb_gray", {23'd0, gray_c}, {23'd0, o.gray});
      chk("sb_run",  {31'd0, running}, {31'd0, o.run});
      chk("sb_wrap", {31'd0, wrap}, {31'd0, o.wrp});
      chk("sb_done", {31'd0, done}, {31'd0, o.dn});
      chk("sb_rdy",  {31'd0, cfg_ready}, {31'd0, o.rdy});
      chk("sb_wcnt", {28'd0, wrap_cnt}, {28'd0, o.wc});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 9'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  logic [8:0] l5_seq [0:5];
  logic [8:0] prev_g;
  int         nwraps;

  initial begin
    l5_seq[0] = 9'd0; l5_seq[1] = 9'd1; l5_seq[2] = 9'd3;
    l5_seq[3] = 9'd2; l5_seq[4] = 9'd6; l5_seq[5] = 9'd7;
    clk = 1'b0; rst = 1'b1; cfg_valid = 1'b0; cfg_limit = '0; cfg_wrap = 1'b0;
    start = 1'b0; pause = 1'b0; abort = 1'b0;

    cyc(1'b0, 9'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 9'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(20);
    chk("rst_gray", {23'd0, gray_c}, 32'd0);
    chk("rst_rdy", {31'd0, cfg_ready}, 32'd1);

    // limit=5 wrap, config and start together
    cyc(1'b1, 9'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("l5_entry", {23'd0, gray_c}, 32'd0);
    for (int k = 1; k <= 12; k++) begin
      idle(1);
      chk("l5_gray", {23'd0, gray_c}, {23'd0, l5_seq[k % 6]});
      chk("l5_wrap", {31'd0, wrap}, (k % 6 == 0) ? 32'd1 : 32'd0);
    end
    chk("l5_wcnt", {28'd0, wrap_cnt}, 32'd2);
    cyc(1'b0, 9'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // limit=3 stop
    cyc(1'b1, 9'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(6);
    chk("l3_done", {31'd0, done}, 32'd1);
    chk("l3_hold", {23'd0, gray_c}, 32'd2);
    chk("l3_rdy", {31'd0, cfg_ready}, 32'd1);
    cyc(1'b0, 9'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("l3_restart", {23'd0, gray_c}, 32'd0);
    chk("l3_run", {31'd0, running}, 32'd1);
    idle(2);

    // reset mid-run restores default limit; full-range run
    cyc(1'b0, 9'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_mid_run", {31'd0, running}, 32'd0);
    cyc(1'b0, 9'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    prev_g = gray_c;
    nwraps = 0;
    for (int k = 1; k <= 512; k++) begin
      idle(1);
      chk("onebit", $countones(prev_g ^ gray_c), 32'd1);
      if (wrap) begin
        nwraps++;
        chk("wrap_from", {23'd0, prev_g}, 32'h100);
      end
      prev_g = gray_c;
    end
    chk("full_wraps", nwraps, 32'd1);
    cyc(1'b0, 9'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // pause at cnt=4, held 3 cycles, resume
    cyc(1'b1, 9'd20, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(4);
    cyc(1'b0, 9'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 9'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("pause_frz", {23'd0, gray_c}, 32'd6);
    end
    cyc(1'b0, 9'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("resume_edge", {23'd0, gray_c}, 32'd6);
    idle(1);
    chk("resume_next", {23'd0, gray_c}, 32'd7);

    // pause and abort together
    cyc(1'b0, 9'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 9'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(4);
    cyc(1'b0, 9'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("pa_abort_g", {23'd0, gray_c}, 32'd0);
    chk("pa_abort_r", {31'd0, running}, 32'd0);

    // config offered during RUN is refused
    cyc(1'b1, 9'd10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 9'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("run_rdy", {31'd0, cfg_ready}, 32'd0);
    idle(12);
    chk("cfg_kept", {23'd0, gray_c}, 32'd15);
    chk("cfg_kept_dn", {31'd0, done}, 32'd1);

    // limit=0 cases
    cyc(1'b1, 9'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 17; k++) idle(1);
    chk("l0_wrap", {31'd0, wrap}, 32'd1);
    chk("l0_sat", {28'd0, wrap_cnt}, 32'hF);
    cyc(1'b0, 9'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 9'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);
    chk("l0_done", {31'd0, done}, 32'd1);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
